// File: rtl/riscv_ctrl_pkg.sv
// Shared control-unit definitions: opcodes, multi-cycle FSM states and datapath mux encodings.
// The ALU decoder imports this package too, so ALUOp codes live here.
package riscv_ctrl_pkg;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_TRAP     = 4'd11
  } state_t;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] RES_ALUOUT  = 2'b00;
  localparam logic [1:0] RES_DATA    = 2'b01;
  localparam logic [1:0] RES_ALU     = 2'b10;

  localparam logic [1:0] SRCA_PC     = 2'b00;
  localparam logic [1:0] SRCA_OLDPC  = 2'b01;
  localparam logic [1:0] SRCA_REG    = 2'b10;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_IMM    = 2'b01;
  localparam logic [1:0] SRCB_FOUR   = 2'b10;

  localparam logic [1:0] IMM_I       = 2'b00;
  localparam logic [1:0] IMM_S       = 2'b01;
  localparam logic [1:0] IMM_B       = 2'b10;
  localparam logic [1:0] IMM_J       = 2'b11;

endpackage

// File: rtl/main_fsm_multicycle_if.sv
// Controller <-> datapath bundle: instruction opcode and memory ready in, enables and selects out.
interface main_fsm_multicycle_if;
  logic [6:0] Op;
  logic       MemReady;
  logic       PCUpdate;
  logic       IRWrite;
  logic       RegWrite;
  logic       MemWrite;
  logic       Branch;
  logic       AdrSrc;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUOp;
  logic [1:0] ImmSrc;

  modport master (
    input  Op, MemReady,
    output PCUpdate, IRWrite, RegWrite, MemWrite, Branch, AdrSrc,
    output ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc
  );

  modport slave (
    output Op, MemReady,
    input  PCUpdate, IRWrite, RegWrite, MemWrite, Branch, AdrSrc,
    input  ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc
  );
endinterface

// File: rtl/imm_src_decoder.sv
// Immediate-format select, decoded straight from the opcode in every state.
module imm_src_decoder
  import riscv_ctrl_pkg::*;
(
  input  logic [6:0] op,
  output logic [1:0] imm_src
);
  always_comb begin
    imm_src = IMM_I;
    case (op)
      OP_SW:   imm_src = IMM_S;
      OP_BEQ:  imm_src = IMM_B;
      OP_JAL:  imm_src = IMM_J;
      default: imm_src = IMM_I;
    endcase
  end
endmodule

// File: rtl/main_fsm_multicycle.sv
// Moore control FSM for the multi-cycle RV32I core, with retired-instruction counter
// and sticky illegal-opcode flag.
module main_fsm_multicycle
  import riscv_ctrl_pkg::*;
#(
  parameter bit MEM_HANDSHAKE = 1'b1,
  parameter int CNT_W         = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  main_fsm_multicycle_if.master bus,
  output logic [3:0]           State,
  output logic [CNT_W-1:0]     InstRet,
  output logic                 IllegalInstr
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic             illegal_q, illegal_d;
  logic             mem_ready;
  logic             retire;
  logic             pc_update, ir_write, reg_write, mem_write, branch, adr_src;
  logic [1:0]       result_src, alu_src_a, alu_src_b, alu_op;
  logic [1:0]       imm_src;

  assign mem_ready = MEM_HANDSHAKE ? bus.MemReady : 1'b1;

  imm_src_decoder u_imm_src_decoder (
    .op      (bus.Op),
    .imm_src (imm_src)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (bus.Op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_I:         state_d = S_EXECI;
          OP_BEQ:       state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
          default:      state_d = S_TRAP;
        endcase
      end
      S_MEMADR:   state_d = (bus.Op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
      S_EXECR,
      S_EXECI,
      S_JAL:      state_d = S_ALUWB;
      S_ALUWB,
      S_BEQ:      state_d = S_FETCH;
      S_TRAP:     state_d = S_TRAP;
      default:    state_d = S_FETCH;
    endcase
  end

  always_comb begin
    pc_update  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    mem_write  = 1'b0;
    branch     = 1'b0;
    adr_src    = 1'b0;
    result_src = RES_ALUOUT;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_REG;
    alu_op     = ALUOP_ADD;
    case (state_q)
      S_FETCH: begin
        // Only the fetch strobes follow MemReady; the selects are pure state decodes.
        ir_write   = mem_ready;
        pc_update  = mem_ready;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALU;
      end
      S_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
      end
      S_MEMADR: begin
        alu_src_a = SRCA_REG;
        alu_src_b = SRCB_IMM;
      end
      S_MEMREAD:  adr_src = 1'b1;
      S_MEMWB: begin
        result_src = RES_DATA;
        reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
      end
      S_EXECR: begin
        alu_src_a = SRCA_REG;
        alu_op    = ALUOP_FUNCT;
      end
      S_EXECI: begin
        alu_src_a = SRCA_REG;
        alu_src_b = SRCB_IMM;
        alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB:    reg_write = 1'b1;
      S_BEQ: begin
        alu_src_a = SRCA_REG;
        alu_op    = ALUOP_SUB;
        branch    = 1'b1;
      end
      S_JAL: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_FOUR;
        pc_update = 1'b1;
      end
      default: ;
    endcase
    // Reset cycle must not let a half-finished instruction write anything.
    if (rst) begin
      pc_update  = 1'b0;
      ir_write   = 1'b0;
      reg_write  = 1'b0;
      mem_write  = 1'b0;
      branch     = 1'b0;
      adr_src    = 1'b0;
      result_src = RES_ALUOUT;
      alu_src_a  = SRCA_PC;
      alu_src_b  = SRCB_REG;
      alu_op     = ALUOP_ADD;
    end
  end

  always_comb begin
    retire = (state_q == S_MEMWB) || (state_q == S_ALUWB) || (state_q == S_BEQ) ||
             ((state_q == S_MEMWRITE) && mem_ready);
    instret_d = instret_q + CNT_W'(retire);
    illegal_d = illegal_q || ((state_q == S_DECODE) && (state_d == S_TRAP));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      instret_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
      illegal_q <= illegal_d;
    end
  end

  assign bus.PCUpdate  = pc_update;
  assign bus.IRWrite   = ir_write;
  assign bus.RegWrite  = reg_write;
  assign bus.MemWrite  = mem_write;
  assign bus.Branch    = branch;
  assign bus.AdrSrc    = adr_src;
  assign bus.ResultSrc = result_src;
  assign bus.ALUSrcA   = alu_src_a;
  assign bus.ALUSrcB   = alu_src_b;
  assign bus.ALUOp     = alu_op;
  assign bus.ImmSrc    = rst ? IMM_I : imm_src;

  assign State        = state_q;
  assign InstRet      = instret_q;
  assign IllegalInstr = illegal_q;

endmodule

// File: tb/tb_main_fsm_multicycle.sv
// Randomized bench: the driver expands each instruction into its expected per-cycle trace,
// a negedge monitor compares; a second no-handshake instance loops lw with MemReady tied low.
module tb_main_fsm_multicycle;
  import riscv_ctrl_pkg::*;

  localparam int CW = 4;
  localparam logic [3:0] NO_ABORT = 4'hF;

  logic clk = 1'b0;
  logic rst;
  logic rst_nohs;
  always #5 clk = ~clk;

  main_fsm_multicycle_if bus ();
  main_fsm_multicycle_if bus2 ();

  logic [3:0]    state, state2;
  logic [CW-1:0] instret;
  logic [31:0]   instret2;
  logic          ill, ill2;

  main_fsm_multicycle #(.MEM_HANDSHAKE(1'b1), .CNT_W(CW)) u_dut (
    .clk(clk), .rst(rst), .bus(bus), .State(state), .InstRet(instret), .IllegalInstr(ill)
  );

  main_fsm_multicycle #(.MEM_HANDSHAKE(1'b0), .CNT_W(32)) u_dut_nohs (
    .clk(clk), .rst(rst_nohs), .bus(bus2), .State(state2), .InstRet(instret2), .IllegalInstr(ill2)
  );

  assign bus2.Op       = OP_LW;
  assign bus2.MemReady = 1'b0;

  typedef struct packed {
    logic [3:0]    st;
    logic [15:0]   ctl;
    logic [CW-1:0] ir;
    logic          il;
  } exp_t;

  typedef struct packed {
    logic [3:0] st;
    logic       rdy;
    logic       ret;
    logic       il;
  } step_t;

  exp_t        exp_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int unsigned mdl_ir;
  bit          mdl_ill;
  logic [6:0]  cur_op;
  int          nohs_cyc = -1;

  // Output table written straight from the per-state list; packing matches the monitor.
  function automatic logic [15:0] spec_ctl(input logic [3:0] st, input logic rdy, input logic [6:0] op);
    logic pcu, irw, rw, mw, br, adr;
    logic [1:0] res, sa, sb, aop, imm;
    {pcu, irw, rw, mw, br, adr} = 6'b0;
    {res, sa, sb, aop} = 8'b0;
    case (op)
      7'b0100011: imm = 2'b01;
      7'b1100011: imm = 2'b10;
      7'b1101111: imm = 2'b11;
      default:    imm = 2'b00;
    endcase
    case (st)
      4'd0:  begin pcu = rdy; irw = rdy; sb = 2'b10; res = 2'b10; end
      4'd1:  begin sa = 2'b01; sb = 2'b01; end
      4'd2:  begin sa = 2'b10; sb = 2'b01; end
      4'd3:  adr = 1'b1;
      4'd4:  begin res = 2'b01; rw = 1'b1; end
      4'd5:  begin adr = 1'b1; mw = 1'b1; end
      4'd6:  begin sa = 2'b10; aop = 2'b10; end
      4'd7:  begin sa = 2'b10; sb = 2'b01; aop = 2'b10; end
      4'd8:  rw = 1'b1;
      4'd9:  begin sa = 2'b10; aop = 2'b01; br = 1'b1; end
      4'd10: begin sa = 2'b01; sb = 2'b10; pcu = 1'b1; end
      default: ;
    endcase
    return {pcu, irw, rw, mw, br, adr, res, sa, sb, aop, imm};
  endfunction

  function automatic step_t mk(input logic [3:0] st, input logic rdy, input logic ret, input logic il);
    return {st, rdy, ret, il};
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic bit legal(input logic [6:0] op);
    return op == OP_LW || op == OP_SW || op == OP_R || op == OP_I || op == OP_BEQ || op == OP_JAL;
  endfunction

  task automatic one_cycle(input logic [3:0] st, input logic rdy, input logic rst_now,
                           input logic ret, input logic setill);
    exp_t e;
    bus.MemReady = rdy;
    rst = rst_now;
    e.st  = st;
    e.ctl = rst_now ? 16'h0 : spec_ctl(st, rdy, cur_op);
    e.ir  = CW'(mdl_ir);
    e.il  = mdl_ill;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (rst_now) begin
      mdl_ir  = 0;
      mdl_ill = 1'b0;
    end else begin
      if (ret)    mdl_ir++;
      if (setill) mdl_ill = 1'b1;
    end
  endtask

  // fst: fetch stalls; mst: memory stalls, or trap dwell cycles for an illegal opcode.
  task automatic run_instr(input logic [6:0] op, input int fst, input int mst, input logic [3:0] abort_st);
    step_t steps[$];
    int unsigned ir0;
    ir0 = mdl_ir;
    cur_op = op;
    bus.Op = op;
    for (int i = 0; i < fst; i++) steps.push_back(mk(4'd0, 1'b0, 1'b0, 1'b0));
    steps.push_back(mk(4'd0, 1'b1, 1'b0, 1'b0));
    steps.push_back(mk(4'd1, rb(), 1'b0, !legal(op)));
    case (op)
      OP_LW: begin
        steps.push_back(mk(4'd2, rb(), 1'b0, 1'b0));
        for (int i = 0; i < mst; i++) steps.push_back(mk(4'd3, 1'b0, 1'b0, 1'b0));
        steps.push_back(mk(4'd3, 1'b1, 1'b0, 1'b0));
        steps.push_back(mk(4'd4, rb(), 1'b1, 1'b0));
      end
      OP_SW: begin
        steps.push_back(mk(4'd2, rb(), 1'b0, 1'b0));
        for (int i = 0; i < mst; i++) steps.push_back(mk(4'd5, 1'b0, 1'b0, 1'b0));
        steps.push_back(mk(4'd5, 1'b1, 1'b1, 1'b0));
      end
      OP_R: begin
        steps.push_back(mk(4'd6, rb(), 1'b0, 1'b0));
        steps.push_back(mk(4'd8, rb(), 1'b1, 1'b0));
      end
      OP_I: begin
        steps.push_back(mk(4'd7, rb(), 1'b0, 1'b0));
        steps.push_back(mk(4'd8, rb(), 1'b1, 1'b0));
      end
      OP_BEQ: steps.push_back(mk(4'd9, rb(), 1'b1, 1'b0));
      OP_JAL: begin
        steps.push_back(mk(4'd10, rb(), 1'b0, 1'b0));
        steps.push_back(mk(4'd8, rb(), 1'b1, 1'b0));
      end
      default: for (int i = 0; i < mst; i++) steps.push_back(mk(4'd11, rb(), 1'b0, 1'b0));
    endcase
    foreach (steps[i]) begin
      if (steps[i].st == abort_st) begin
        one_cycle(steps[i].st, steps[i].rdy, 1'b1, 1'b0, 1'b0);
        $display("abort  op=%b reset in state %0d", op, steps[i].st);
        return;
      end
      one_cycle(steps[i].st, steps[i].rdy, 1'b0, steps[i].ret, steps[i].il);
    end
    $display("instr  op=%b cycles=%0d retired=%0d instret=%0d", op, steps.size(), mdl_ir - ir0, mdl_ir % 16);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, req, $time);
    end
  endtask

  always @(posedge clk) begin
    if (rst_nohs)          nohs_cyc <= 0;
    else if (nohs_cyc >= 0) nohs_cyc <= nohs_cyc + 1;
  end

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("state", 32'(state), 32'(e.st));
      chk("ctl", 32'({bus.PCUpdate, bus.IRWrite, bus.RegWrite, bus.MemWrite, bus.Branch, bus.AdrSrc,
                      bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp, bus.ImmSrc}), 32'(e.ctl));
      chk("instret", 32'(instret), 32'(e.ir));
      chk("illegal", 32'(ill), 32'(e.il));
    end
    // Without handshake, lw cycles FETCH..MEMWB every 5 clocks regardless of MemReady.
    if (!rst_nohs && nohs_cyc >= 0 && nohs_cyc < 60) begin
      chk("nohs_state", 32'(state2), 32'(nohs_cyc % 5));
      chk("nohs_instret", instret2, 32'(nohs_cyc / 5));
      chk("nohs_irwrite", 32'(bus2.IRWrite), 32'(nohs_cyc % 5 == 0));
    end
  end

  initial begin
    logic [6:0] ops[6];
    logic [6:0] bad_op;
    ops[0] = OP_LW; ops[1] = OP_SW; ops[2] = OP_R;
    ops[3] = OP_I;  ops[4] = OP_BEQ; ops[5] = OP_JAL;
    rst = 1'b1;
    rst_nohs = 1'b1;
    bus.Op = OP_LW;
    bus.MemReady = 1'b0;
    cur_op = OP_LW;
    mdl_ir = 0;
    mdl_ill = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_nohs = 1'b0;
    one_cycle(4'd0, 1'b0, 1'b1, 1'b0, 1'b0);

    run_instr(OP_LW, 0, 0, NO_ABORT);
    run_instr(OP_SW, 0, 3, NO_ABORT);
    run_instr(OP_R, 0, 0, NO_ABORT);
    run_instr(OP_I, 0, 0, NO_ABORT);
    run_instr(OP_BEQ, 0, 0, NO_ABORT);
    run_instr(OP_JAL, 0, 0, NO_ABORT);

    for (int n = 0; n < 60; n++)
      run_instr(ops[$urandom_range(0, 5)], int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), NO_ABORT);

    run_instr(OP_SW, 1, 3, 4'd5);
    run_instr(OP_R, 0, 0, NO_ABORT);
    run_instr(OP_LW, 0, 2, 4'd3);
    run_instr(OP_BEQ, 2, 0, NO_ABORT);

    bad_op = 7'b1111111;
    run_instr(bad_op, 0, 20, NO_ABORT);
    one_cycle(4'd11, 1'b1, 1'b1, 1'b0, 1'b0);
    do bad_op = 7'($urandom); while (legal(bad_op));
    run_instr(bad_op, 1, 5, NO_ABORT);
    one_cycle(4'd11, 1'b0, 1'b1, 1'b0, 1'b0);
    run_instr(OP_LW, 0, 1, NO_ABORT);

    @(negedge clk);
    #1;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/main_fsm_multicycle.md
# main_fsm_multicycle

Multi-cycle successor to the single-cycle main decoder: a Moore state machine that sequences each RV32I instruction (lw, sw, R-type, I-type ALU, beq, jal) over 3–5 cycles. It drives every datapath enable and mux select of the multi-cycle core, and optionally stalls on a memory ready handshake. It also keeps a retired-instruction counter and a sticky illegal-opcode flag. It sits in the control unit beside the existing ALU decoder, which consumes ALUOp.

## Interface
- MEM_HANDSHAKE, 1: 1 = honour MemReady in memory states; 0 = treat MemReady as constant 1.
- CNT_W, 32: width of InstRet counter.

- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- Op  in  7  opcode from instruction register (stable outside FETCH)
- MemReady  in  1  unified memory completes access this cycle
- PCUpdate, IRWrite, RegWrite, MemWrite, Branch, AdrSrc  out  1 each  datapath enables/select
- ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc  out  2 each  mux selects
- State  out  4  current state (debug)
- InstRet  out  CNT_W  retired-instruction count
- IllegalInstr  out  1  sticky: unsupported opcode decoded

## Operation
- Encodings: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BEQ=9, JAL=10, TRAP=11; codes 12–15 go to FETCH.
- Opcodes: lw 0000011, sw 0100011, R 0110011, I 0010011, beq 1100011, jal 1101111.
- Transitions:
  - FETCH→DECODE once MemReady=1; otherwise hold.
  - DECODE→MEMADR (lw/sw), EXECR (R), EXECI (I), BEQ (beq), JAL (jal); any other opcode →TRAP.
  - MEMADR→MEMREAD (lw) or MEMWRITE (sw).
  - MEMREAD→MEMWB once MemReady=1; otherwise hold.
  - MEMWB→FETCH.
  - MEMWRITE→FETCH once MemReady=1; otherwise hold.
  - EXECR and EXECI→ALUWB; JAL→ALUWB; ALUWB→FETCH; BEQ→FETCH.
  - TRAP holds until rst.
- Outputs per state. Every signal not listed is 0 and every select not listed is 00.
  - FETCH: IRWrite=1 and PCUpdate=1, qualified by MemReady; ALUSrcB=10; ResultSrc=10.
  - DECODE: ALUSrcA=01, ALUSrcB=01.
  - MEMADR: ALUSrcA=10, ALUSrcB=01.
  - MEMREAD: AdrSrc=1.
  - MEMWB: ResultSrc=01, RegWrite=1.
  - MEMWRITE: AdrSrc=1; MemWrite=1 held every cycle until MemReady.
  - EXECR: ALUSrcA=10, ALUOp=10.
  - EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10.
  - ALUWB: RegWrite=1.
  - BEQ: ALUSrcA=10, ALUOp=01, Branch=1.
  - JAL: ALUSrcA=01, ALUSrcB=10, PCUpdate=1.
  - TRAP: all enables 0.
- ImmSrc is combinational from Op in every state: lw/I 00, sw 01, beq 10, jal 11, other 00.
- Retire: InstRet increments by 1 on each cycle that leaves MEMWB, ALUWB or BEQ, or completes MEMWRITE. The counter wraps modulo 2^CNT_W.
- IllegalInstr sets on the DECODE→TRAP transition and clears only on rst.

## Timing
- During rst=1: next state=FETCH, InstRet=0, IllegalInstr=0. All enables are forced to 0 and all selects to 00 in that cycle, including mid-instruction and with a pending MemWrite.
- First cycle after reset release: state FETCH.
- Latency with MemReady=1 and FETCH counted: beq 3 cycles; R/I/sw 4; jal 4; lw 5.
- Each cycle MemReady=0 in FETCH, MEMREAD or MEMWRITE adds exactly one cycle. Enables held in those states stay stable during the stall; no retire occurs.
- All outputs except ImmSrc and the MemReady-qualified enables are registered-state decodes with no Op dependence, so they are glitch-free relative to Op.

## Structure
- Shared package riscv_ctrl_pkg: opcode constants, state enumeration, and ALUOp/ResultSrc/ALUSrc encodings. The existing ALU decoder reuses the same package.
- Single module; the combinational ImmSrc decode may be a small sub-module, imm_src_decoder.

## Test plan
- Reset, then lw with MemReady=1: states 0,1,2,3,4,0; RegWrite=1 only in MEMWB with ResultSrc=01; InstRet=1.
- sw with MemReady=0 for 3 cycles in MEMWRITE: MemWrite=1 for 4 consecutive cycles, AdrSrc=1; single retire.
- Sequence R, I, beq, jal: cycle counts 4,4,3,4; ALUOp 10,10,01,00; jal ends in ALUWB with RegWrite=1; InstRet=4.
- Op=1111111 in DECODE: enters TRAP; IllegalInstr=1 held for 20 cycles with no enables; rst clears both.
- rst asserted in MEMWRITE and in MEMREAD stall: outputs zero that cycle, FETCH next, InstRet=0.
- CNT_W=4 after 16 retires: InstRet wraps to 0. MEM_HANDSHAKE=0 with MemReady tied 0: lw still completes in 5 cycles.
